// File: rtl/quadrature_generator.sv
// Quadrature A/B waveform generator: queues single-cycle step requests in a
// saturating signed counter and emits one rate-limited Gray-code transition per step.
module quadrature_generator #(
   parameter int HALF_PERIOD_CYCLES = 50000,
   parameter int DWELL_WIDTH        = 17,
   parameter int PENDING_WIDTH      = 4,
   parameter int POS_WIDTH          = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        stepCW,
   input  logic                        stepCCW,
   output logic                        A,
   output logic                        B,
   output logic                        busy,
   output logic                        overflow,
   output logic signed [POS_WIDTH-1:0] position
);

   typedef enum logic {IDLE, DWELL} state_t;

   localparam int PEND_MAX_I = 2 ** (PENDING_WIDTH - 1) - 1;
   localparam logic signed [PENDING_WIDTH:0] PEND_MAX = (PENDING_WIDTH + 1)'(PEND_MAX_I);
   localparam logic signed [PENDING_WIDTH:0] PEND_ONE = (PENDING_WIDTH + 1)'(1);
   localparam logic [DWELL_WIDTH-1:0]        DWELL_LOAD = DWELL_WIDTH'(HALF_PERIOD_CYCLES - 1);

   state_t                            state, state_next;
   logic [DWELL_WIDTH-1:0]            dwell, dwell_next;
   logic signed [PENDING_WIDTH-1:0]   pending, pending_next;
   logic signed [PENDING_WIDTH:0]     net;
   logic                              issue_cw, issue_ccw, ready, drop;

   always_comb begin
      // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
      state_next   = state;
      dwell_next   = dwell;
      issue_cw     = 1'b0;
      issue_ccw    = 1'b0;
      ready        = (state == IDLE) || (dwell == '0);

      if (ready) begin
         issue_cw  = (pending > 0);
         issue_ccw = (pending < 0);
      end

      if (issue_cw || issue_ccw) begin
         state_next = DWELL;
         dwell_next = DWELL_LOAD;
      end else if (ready) begin
         state_next = IDLE;
      end else begin
         dwell_next = dwell - 1'b1;
      end

      // One extra bit of headroom so the out-of-range sum is visible before clamping.
      net = (PENDING_WIDTH + 1)'(pending);
      if (stepCW)    net = net + PEND_ONE;
      if (stepCCW)   net = net - PEND_ONE;
      if (issue_cw)  net = net - PEND_ONE;
      if (issue_ccw) net = net + PEND_ONE;

      drop         = (net > PEND_MAX) || (net < -PEND_MAX);
      pending_next = drop ? pending : net[PENDING_WIDTH-1:0];
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         dwell    <= '0;
         pending  <= '0;
         A        <= 1'b0;
         B        <= 1'b0;
         overflow <= 1'b0;
         position <= '0;
      end else begin
         state    <= state_next;
         dwell    <= dwell_next;
         pending  <= pending_next;
         overflow <= drop;
         // Gray walk: CW 00->01->11->10, CCW the reverse; only one channel flips.
         if (issue_cw) begin
            A        <= B;
            B        <= ~A;
            position <= position + POS_WIDTH'(1);
         end else if (issue_ccw) begin
            A        <= ~B;
            B        <= A;
            position <= position - POS_WIDTH'(1);
         end
      end
   end

   assign busy = (pending != '0) || (state == DWELL);

endmodule
